// File: rtl/dmux_stream.sv
// dmux_stream: 1-to-N_OUT stream demultiplexer with valid/ready flow control.
// Each output channel has a one-entry registered holding stage. With LOCK=1 the
// destination is captured on the first beat of a packet and kept until the last
// beat. Beats addressed to a non-existent channel are accepted and discarded,
// flagged on err and counted in a saturating drop_cnt.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_valid/s_ready     input handshake; s_data, s_sel, s_last travel with the beat
//   m_valid/m_ready     per-channel output handshake
//   m_data              packed channel data, channel k at [k*DATA_W +: DATA_W]
//   m_last              per-channel last flag
//   err                 one-cycle pulse after a beat was dropped
//   drop_cnt            saturating count of dropped beats
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | between packets; destination taken from s_sel on every beat
// IN_PKT | inside a multi-beat packet; destination held in locked_sel

module dmux_stream #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int LOCK   = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_last,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_last,
  output logic                    err,
  output logic [CNT_W-1:0]        drop_cnt
);

  // One extra bit so the compare works when N_OUT == 2**SEL_W.
  localparam logic [SEL_W:0] N_OUT_V = (SEL_W+1)'(N_OUT);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t             state;
  logic [SEL_W-1:0]   locked_sel;
  logic [SEL_W-1:0]   eff_sel;
  logic               in_range;
  logic               accept;
  logic               drop;
  logic [N_OUT-1:0]   hit;
  logic [N_OUT-1:0]   load;

  assign eff_sel  = (state == IN_PKT) ? locked_sel : s_sel;
  assign in_range = {1'b0, eff_sel} < N_OUT_V;

  // One-hot decode of the destination; all zero when eff_sel is out of range.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit[k] = (eff_sel == SEL_W'(k));
    end
  end

  // A channel can take a beat when empty or draining this cycle; out-of-range
  // beats are always taken so the producer never stalls on a bad select.
  assign s_ready = !in_range || |(hit & (~m_valid | m_ready));
  assign accept  = s_valid && s_ready;
  assign load    = {N_OUT{accept}} & hit;
  assign drop    = accept && !in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid    <= '0;
      m_data     <= '0;
      m_last     <= '0;
      err        <= 1'b0;
      drop_cnt   <= '0;
      state      <= IDLE;
      locked_sel <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        // Load wins over drain so a back-to-back beat replaces the old one.
        if (load[k]) begin
          m_valid[k]                  <= 1'b1;
          m_data[k*DATA_W +: DATA_W]  <= s_data;
          m_last[k]                   <= s_last;
        end else if (m_ready[k]) begin
          m_valid[k] <= 1'b0;
        end
      end

      err <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      if ((LOCK != 0) && accept) begin
        case (state)
          IDLE: begin
            if (!s_last) begin
              state      <= IN_PKT;
              locked_sel <= s_sel;
            end
          end
          IN_PKT: begin
            if (s_last) begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmux_stream.sv
// Testbench for dmux_stream. Two instances share one stimulus stream:
//   u_lock : N_OUT=4, LOCK=1 (packet lock, every select in range)
//   u_flat : N_OUT=3, LOCK=0 (select 3 is out of range and dropped)
// A behavioural model tracks per-channel occupancy and contents, the packet
// destination and the drop count, and is compared every cycle; directed steps
// add explicit constant expectations.

module tb_dmux_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [1:0]  s_sel;
  logic        s_last;
  logic [3:0]  m_ready;

  logic        rdy0, err0;
  logic [3:0]  mv0, ml0;
  logic [31:0] md0;
  logic [7:0]  cnt0;

  logic        rdy1, err1;
  logic [2:0]  mv1, ml1;
  logic [23:0] md1;
  logic [7:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmux_stream #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .LOCK(1), .CNT_W(8)) u_lock (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data),
    .s_sel(s_sel), .s_last(s_last), .m_valid(mv0), .m_ready(m_ready),
    .m_data(md0), .m_last(ml0), .err(err0), .drop_cnt(cnt0)
  );

  dmux_stream #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .LOCK(0), .CNT_W(8)) u_flat (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
    .s_sel(s_sel), .s_last(s_last), .m_valid(mv1), .m_ready(m_ready[2:0]),
    .m_data(md1), .m_last(ml1), .err(err1), .drop_cnt(cnt1)
  );

  // Reference model: index 0 = u_lock, 1 = u_flat.
  bit       mv [2][4];
  bit [7:0] md [2][4];
  bit       ml [2][4];
  bit       merr [2];
  int       mcnt [2];
  bit       mlock;   // u_lock is inside a multi-beat packet
  int       mch;     // u_lock packet destination

  function automatic int nout(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int msel(int d);
    return (d == 0 && mlock) ? mch : int'(s_sel);
  endfunction

  function automatic bit mrdy(int d);
    int sel;
    sel = msel(d);
    if (sel >= nout(d)) return 1'b1;
    return !mv[d][sel] || m_ready[sel];
  endfunction

  task automatic model_edge();
    int sel;
    bit acc;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int k = 0; k < 4; k++) begin
          mv[d][k] = 1'b0;
          md[d][k] = 8'h00;
          ml[d][k] = 1'b0;
        end
        merr[d] = 1'b0;
        mcnt[d] = 0;
        if (d == 0) begin
          mlock = 1'b0;
          mch   = 0;
        end
      end else begin
        sel = msel(d);
        acc = s_valid && mrdy(d);
        for (int k = 0; k < nout(d); k++) begin
          if (mv[d][k] && m_ready[k]) mv[d][k] = 1'b0;
        end
        merr[d] = 1'b0;
        if (acc) begin
          if (sel < nout(d)) begin
            mv[d][sel] = 1'b1;
            md[d][sel] = s_data;
            ml[d][sel] = s_last;
          end else begin
            merr[d] = 1'b1;
            if (mcnt[d] < 255) mcnt[d]++;
          end
        end
        if (d == 0 && acc) begin
          if (!mlock) mch = int'(s_sel);
          mlock = !s_last;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_valid(int d);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nout(d); k++) v[k] = mv[d][k];
    return v;
  endfunction

  function automatic logic [31:0] exp_last(int d);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nout(d); k++) v[k] = ml[d][k];
    return v;
  endfunction

  function automatic logic [31:0] exp_data(int d);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nout(d); k++) v[k*8 +: 8] = md[d][k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("m_valid0",  32'(mv0),  exp_valid(0));
    chk("m_data0",   md0,       exp_data(0));
    chk("m_last0",   32'(ml0),  exp_last(0));
    chk("err0",      32'(err0), 32'(merr[0]));
    chk("drop_cnt0", 32'(cnt0), 32'(mcnt[0]));
    chk("m_valid1",  32'(mv1),  exp_valid(1));
    chk("m_data1",   32'(md1),  exp_data(1));
    chk("m_last1",   32'(ml1),  exp_last(1));
    chk("err1",      32'(err1), 32'(merr[1]));
    chk("drop_cnt1", 32'(cnt1), 32'(mcnt[1]));
  endtask

  // Inputs are set just after an edge; s_ready is checked once they settle,
  // the model steps on the edge and outputs are compared 1 time unit later.
  task automatic tick();
    #2;
    chk("s_ready0", 32'(rdy0), 32'(mrdy(0)));
    chk("s_ready1", 32'(rdy1), 32'(mrdy(1)));
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [7:0] d, input bit last);
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
    s_last  = last;
  endtask

  initial begin
    reset   = 1'b1;
    m_ready = 4'hf;
    drive(0, 2'd0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    chk("rst_valid0", 32'(mv0), 32'h0);
    chk("rst_data0",  md0,      32'h0);
    chk("rst_cnt0",   32'(cnt0), 32'h0);
    chk("rst_cnt1",   32'(cnt1), 32'h0);

    // Idle: ready for every select.
    for (int i = 0; i < 4; i++) begin
      s_sel = 2'(i);
      #1;
      chk("idle_ready0", 32'(rdy0), 32'h1);
      chk("idle_ready1", 32'(rdy1), 32'h1);
    end

    // Single beat to channel 2, one-cycle latency, then drains.
    drive(1, 2'd2, 8'hA5, 1);
    tick();
    chk("single_valid", 32'(mv0), 32'h4);
    chk("single_data",  32'(md0[23:16]), 32'hA5);
    chk("single_last",  32'(ml0[2]), 32'h1);
    drive(0, 2'd0, 8'h00, 0);
    tick();
    chk("single_drain", 32'(mv0), 32'h0);
    chk("single_hold",  32'(md0[23:16]), 32'hA5);

    // Backpressure on channel 1, then simultaneous drain and load.
    m_ready = 4'b1101;
    drive(1, 2'd1, 8'h11, 1);
    tick();
    drive(1, 2'd1, 8'h22, 1);
    #1;
    chk("bp_ready", 32'(rdy0), 32'h0);
    tick();
    chk("bp_hold", 32'(md0[15:8]), 32'h11);
    m_ready = 4'hf;
    tick();
    chk("bp_swap_valid", 32'(mv0[1]), 32'h1);
    chk("bp_swap_data",  32'(md0[15:8]), 32'h22);
    drive(0, 2'd0, 8'h00, 0);
    tick();
    chk("bp_drain", 32'(mv0[1]), 32'h0);

    // Packet lock: destination from the first beat only.
    drive(1, 2'd3, 8'h01, 0);
    tick();
    chk("lock_b0", {mv0, md0[31:24]}, {20'h0, 4'b1000, 8'h01});
    drive(1, 2'd0, 8'h02, 0);
    tick();
    chk("lock_b1", {mv0, md0[31:24]}, {20'h0, 4'b1000, 8'h02});
    drive(1, 2'd0, 8'h03, 1);
    tick();
    chk("lock_b2", {mv0, md0[31:24]}, {20'h0, 4'b1000, 8'h03});
    chk("lock_last", 32'(ml0[3]), 32'h1);
    drive(1, 2'd0, 8'h04, 1);
    tick();
    chk("lock_next", {mv0, md0[7:0]}, {20'h0, 4'b0001, 8'h04});
    drive(0, 2'd0, 8'h00, 0);
    tick();

    // Drops on the 3-channel instance, counter saturation.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 2'd3, 8'h55, 1);
    #1;
    chk("drop_ready", 32'(rdy1), 32'h1);
    tick();
    chk("drop_err",   32'(err1), 32'h1);
    chk("drop_cnt",   32'(cnt1), 32'h1);
    chk("drop_nov",   32'(mv1),  32'h0);
    drive(0, 2'd0, 8'h00, 0);
    tick();
    chk("drop_err_clr", 32'(err1), 32'h0);
    drive(1, 2'd3, 8'h56, 1);
    repeat (259) tick();
    chk("drop_sat", 32'(cnt1), 32'd255);
    chk("drop_err_run", 32'(err1), 32'h1);
    drive(0, 2'd0, 8'h00, 0);
    tick();

    // Reset while a packet to channel 2 is stalled.
    m_ready = 4'b1011;
    drive(1, 2'd2, 8'h31, 0);
    tick();
    drive(1, 2'd2, 8'h32, 0);
    tick();
    chk("mid_held", 32'(mv0[2]), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst", 32'(mv0), 32'h0);
    m_ready = 4'hf;
    drive(1, 2'd0, 8'h40, 1);
    tick();
    chk("mid_route", {mv0, md0[7:0]}, {20'h0, 4'b0001, 8'h40});
    drive(0, 2'd0, 8'h00, 0);
    tick();

    // Full throughput alternating channels 0 and 1.
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'(i % 2), 8'(8'h60 + i), 1);
      #1;
      chk("tput_ready", 32'(rdy1), 32'h1);
      tick();
      chk("tput_valid", 32'(mv1), (i % 2) ? 32'h2 : 32'h1);
      chk("tput_data",  32'(md1[(i % 2)*8 +: 8]), 32'(8'h60 + i));
    end
    drive(0, 2'd0, 8'h00, 0);
    tick();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      reset   = ($urandom_range(0, 49) == 0);
      m_ready = 4'($urandom);
      drive(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            8'($urandom), ($urandom_range(0, 3) == 0));
      tick();
    end
    reset = 1'b0;
    drive(0, 2'd0, 8'h00, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
